// File: rtl/ifft_b2s_pingpong_buf.sv
// IFFT block-to-stream ping-pong buffer: writes one (optionally bit-reversed) symbol per bank,
// then streams each full bank out in natural order under valid/ready backpressure.
module ifft_b2s_pingpong_buf #(
    parameter int DATA_W   = 16,
    parameter int NCH      = 2,
    parameter int MIN_LOG2 = 7,
    parameter int MAX_LOG2 = 12
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [3:0]                 cfg_nfft_log2,
    input  logic                       cfg_bitrev,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sop,
    input  logic [2*DATA_W*NCH-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [2*DATA_W*NCH-1:0]    out_data,
    output logic [3:0]                 out_nfft_log2,
    output logic                       err_sop,
    output logic                       dbg_wstate,
    output logic                       dbg_rstate
);

    localparam int W     = 2 * DATA_W * NCH;
    localparam int AW    = MAX_LOG2;
    localparam int CW    = MAX_LOG2 + 1;
    localparam int DEPTH = 1 << (AW + 1);

    typedef enum logic { W_IDLE = 1'b0, W_FILL = 1'b1 } wstate_t;
    typedef enum logic { R_IDLE = 1'b0, R_DRAIN = 1'b1 } rstate_t;

    function automatic logic [3:0] clamp_n(input logic [3:0] n);
        if (int'(n) < MIN_LOG2) return 4'(MIN_LOG2);
        if (int'(n) > MAX_LOG2) return 4'(MAX_LOG2);
        return n;
    endfunction

    function automatic logic [CW-1:0] blk_len(input logic [3:0] n);
        return CW'(1) << n;
    endfunction

    // Reverse all AW bits, then shift down so only the low n bits are mirrored.
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] k, input logic [3:0] n,
                                               input logic br);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
        if (br) return r >> (AW - int'(n));
        return k;
    endfunction

    // Both ports use the usual handshake: a word moves on a clock edge where valid and
    // ready are both high; the producer holds valid/data steady until that edge.
    wstate_t        wstate_q, wstate_d;
    logic           wbank_q, wbank_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    logic [1:0][3:0] bank_n_q, bank_n_d;
    logic [1:0]     bank_br_q, bank_br_d;
    logic [1:0]     full_q, full_d;
    logic           in_ready_q, in_ready_d;
    logic           err_q, err_d;
    logic           we, set_full, accept;
    logic [AW-1:0]  waddr;
    logic [3:0]     n_sop;

    rstate_t        rstate_q, rstate_d;
    logic           rbank_q, rbank_d;
    logic [CW-1:0]  rcnt_q, rcnt_d;
    logic           out_valid_q, out_valid_d;
    logic           out_sop_q, out_sop_d;
    logic           out_eop_q, out_eop_d;
    logic [3:0]     out_nfft_q, out_nfft_d;
    logic [W-1:0]   out_data_q;
    logic           ld_mem, clr_full, load;
    logic [AW-1:0]  raddr;
    logic [3:0]     rn;

    logic [W-1:0]   mem [DEPTH];

    // Writer
    always_comb begin
        wstate_d  = wstate_q;
        wbank_d   = wbank_q;
        wcnt_d    = wcnt_q;
        bank_n_d  = bank_n_q;
        bank_br_d = bank_br_q;
        set_full  = 1'b0;
        err_d     = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        accept    = in_valid && in_ready_q;
        n_sop     = clamp_n(cfg_nfft_log2);
        case (wstate_q)
            W_IDLE: begin
                if (accept) begin
                    if (in_sop) begin
                        we                 = 1'b1;
                        bank_n_d[wbank_q]  = n_sop;
                        bank_br_d[wbank_q] = cfg_bitrev;
                        wcnt_d             = CW'(1);
                        wstate_d           = W_FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (accept) begin
                    we = 1'b1;
                    if (in_sop) begin
                        // Restart: the partial block is abandoned and this sample becomes k = 0.
                        err_d              = 1'b1;
                        bank_n_d[wbank_q]  = n_sop;
                        bank_br_d[wbank_q] = cfg_bitrev;
                        wcnt_d             = CW'(1);
                    end else begin
                        waddr = map_addr(wcnt_q[AW-1:0], bank_n_q[wbank_q], bank_br_q[wbank_q]);
                        if (wcnt_q == blk_len(bank_n_q[wbank_q]) - CW'(1)) begin
                            set_full = 1'b1;
                            wbank_d  = ~wbank_q;
                            wcnt_d   = '0;
                            wstate_d = W_IDLE;
                        end else begin
                            wcnt_d = wcnt_q + CW'(1);
                        end
                    end
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Reader: the output register doubles as the RAM read register (1-cycle read latency).
    always_comb begin
        rstate_d    = rstate_q;
        rbank_d     = rbank_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_nfft_d  = out_nfft_q;
        ld_mem      = 1'b0;
        clr_full    = 1'b0;
        raddr       = '0;
        rn          = bank_n_q[rbank_q];
        load        = !out_valid_q || out_ready;
        case (rstate_q)
            R_IDLE: begin
                if (full_q[rbank_q] && load) begin
                    ld_mem      = 1'b1;
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b1;
                    out_eop_d   = 1'b0;
                    out_nfft_d  = rn;
                    rcnt_d      = CW'(1);
                    rstate_d    = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (load) begin
                    if (rcnt_q == blk_len(rn)) begin
                        out_valid_d = 1'b0;
                        out_sop_d   = 1'b0;
                        out_eop_d   = 1'b0;
                        clr_full    = 1'b1;
                        rbank_d     = ~rbank_q;
                        rcnt_d      = '0;
                        rstate_d    = R_IDLE;
                    end else begin
                        ld_mem    = 1'b1;
                        raddr     = rcnt_q[AW-1:0];
                        out_sop_d = 1'b0;
                        out_eop_d = (rcnt_q == blk_len(rn) - CW'(1));
                        rcnt_d    = rcnt_q + CW'(1);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // A bank freed and filled in the same cycle are always different banks.
    always_comb begin
        full_d = full_q;
        if (clr_full) full_d[rbank_q] = 1'b0;
        if (set_full) full_d[wbank_q] = 1'b1;
        in_ready_d = (wstate_d == W_FILL) || !full_d[wbank_d];
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wbank_q, waddr}] <= in_data;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wstate_q   <= W_IDLE;
            wbank_q    <= 1'b0;
            wcnt_q     <= '0;
            bank_n_q   <= '0;
            bank_br_q  <= '0;
            full_q     <= '0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            wbank_q    <= wbank_d;
            wcnt_q     <= wcnt_d;
            bank_n_q   <= bank_n_d;
            bank_br_q  <= bank_br_d;
            full_q     <= full_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rstate_q    <= R_IDLE;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_nfft_q  <= '0;
            out_data_q  <= '0;
        end else begin
            rstate_q    <= rstate_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_nfft_q  <= out_nfft_d;
            if (ld_mem) out_data_q <= mem[{rbank_q, raddr}];
        end
    end

    assign in_ready      = in_ready_q;
    assign err_sop       = err_q;
    assign out_valid     = out_valid_q;
    assign out_sop       = out_sop_q;
    assign out_eop       = out_eop_q;
    assign out_nfft_log2 = out_nfft_q;
    assign out_data      = out_data_q;
    assign dbg_wstate    = wstate_q;
    assign dbg_rstate    = rstate_q;

endmodule

// File: tb/tb_ifft_b2s_pingpong_buf.sv
// Directed bench for ifft_b2s_pingpong_buf: ordering, bit-reversal, back-to-back,
// backpressure, protocol errors, size clamp and mid-stream reset.
module tb_ifft_b2s_pingpong_buf;

    localparam int W = 64;

    logic         clk;
    logic         areset;
    logic [3:0]   cfg_nfft_log2;
    logic         cfg_bitrev;
    logic         in_valid;
    logic         in_ready;
    logic         in_sop;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sop;
    logic         out_eop;
    logic [W-1:0] out_data;
    logic [3:0]   out_nfft_log2;
    logic         err_sop;
    logic         dbg_wstate;
    logic         dbg_rstate;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [5:0]   got_fl[$];

    logic         hold_q = 1'b0;
    logic [W-1:0] hold_data;
    logic [5:0]   hold_fl;

    ifft_b2s_pingpong_buf dut (
        .clk(clk), .areset(areset),
        .cfg_nfft_log2(cfg_nfft_log2), .cfg_bitrev(cfg_bitrev),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .out_nfft_log2(out_nfft_log2), .err_sop(err_sop),
        .dbg_wstate(dbg_wstate), .dbg_rstate(dbg_rstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int v);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        a = 16'(v + 1000);
        b = 16'(v);
        c = 16'(-v);
        return {a, 16'd0, b, c};
    endfunction

    function automatic int brev(input int k, input int nb);
        int r;
        r = 0;
        for (int i = 0; i < nb; i++) r = r | (((k >> i) & 1) << (nb - 1 - i));
        return r;
    endfunction

    // Presents one word and returns just after the edge that accepted it; in_valid stays high.
    task automatic send(input logic sop, input logic [W-1:0] d, input logic [3:0] nl,
                        input logic br);
        in_valid      = 1'b1;
        in_sop        = sop;
        in_data       = d;
        cfg_nfft_log2 = nl;
        cfg_bitrev    = br;
        for (int i = 0; i < 3000 && !in_ready; i++) begin
            tick();
            stall_cnt++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_sop = 1'b0;
    endtask

    task automatic check_block(input string tag, input int n, input int nblk,
                               input logic [3:0] nl);
        int total;
        total = n * nblk;
        for (int i = 0; i < total * 4 + 400 && got_q.size() < total; i++) tick();
        chk({tag, "_beats"}, 64'(got_q.size()), 64'(total));
        for (int j = 0; j < total && j < got_q.size(); j++) begin
            chk({tag, "_data"}, got_q[j], exp_q[j]);
            chk({tag, "_flags"}, 64'(got_fl[j]),
                64'({(j % n == 0), (j % n == n - 1), nl}));
        end
        got_q.delete();
        got_fl.delete();
        exp_q.delete();
    endtask

    // Output monitor: records accepted beats and checks that held beats stay put.
    always @(negedge clk) begin
        if (hold_q && !areset) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, hold_data);
            chk("hold_flags", 64'({out_sop, out_eop, out_nfft_log2}), 64'(hold_fl));
        end
        hold_q    = out_valid && !out_ready && !areset;
        hold_data = out_data;
        hold_fl   = {out_sop, out_eop, out_nfft_log2};
        if (out_valid && out_ready && !areset) begin
            got_q.push_back(out_data);
            got_fl.push_back({out_sop, out_eop, out_nfft_log2});
        end
    end

    initial begin
        areset        = 1'b0;
        cfg_nfft_log2 = 4'd7;
        cfg_bitrev    = 1'b0;
        in_valid      = 1'b0;
        in_sop        = 1'b0;
        in_data       = '0;
        out_ready     = 1'b1;
        #2 areset = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_flags", 64'({out_sop, out_eop, out_nfft_log2, err_sop}), 64'd0);
        chk("rst_dbg", 64'({dbg_wstate, dbg_rstate}), 64'd0);
        areset = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Natural order, N=7, with latency check
        for (int k = 0; k < 128; k++) begin
            send(k == 0, pat(k), 4'd7, 1'b0);
            exp_q.push_back(pat(k));
            if (k == 5) chk("t1_wstate_fill", 64'(dbg_wstate), 64'd1);
        end
        in_valid = 1'b0;
        chk("t1_lat_t1", 64'(out_valid), 64'd0);
        tick();
        chk("t1_lat_t2", 64'(out_valid), 64'd1);
        chk("t1_first_nfft", 64'(out_nfft_log2), 64'd7);
        check_block("t1", 128, 1, 4'd7);

        // Bit-reversed input, N=8
        for (int k = 0; k < 256; k++) begin
            send(k == 0, pat(brev(k, 8)), 4'd8, 1'b1);
            exp_q.push_back(pat(k));
        end
        in_valid = 1'b0;
        check_block("t2", 256, 1, 4'd8);

        // Back-to-back: three N=7 blocks with in_valid held high
        stall_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 128; k++) begin
                send(k == 0, pat(128 * b + k), 4'd7, 1'b0);
                exp_q.push_back(pat(128 * b + k));
            end
        end
        in_valid = 1'b0;
        chk("t3_stalls", 64'(stall_cnt), 64'd1);
        check_block("t3", 128, 3, 4'd7);

        // Backpressure, N=9
        out_ready = 1'b0;
        for (int k = 0; k < 512; k++) begin
            send(k == 0, pat(2000 + k), 4'd9, 1'b0);
            exp_q.push_back(pat(2000 + k));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6000 && got_q.size() < 512; i++) begin
            case ($urandom_range(0, 3))
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                2: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            tick();
        end
        out_ready = 1'b1;
        check_block("t4", 512, 1, 4'd9);

        // Stray sample while idle
        send(1'b0, pat(77), 4'd7, 1'b0);
        chk("t5_stray_err", 64'(err_sop), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("t5_stray_err_end", 64'(err_sop), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_stray_dropped", 64'(got_q.size()), 64'd0);

        // sop at count 50 restarts the block
        for (int k = 0; k < 50; k++) begin
            send(k == 0, pat(500 + k), 4'd7, 1'b0);
            if (k == 0) chk("t5_first_sop_ok", 64'(err_sop), 64'd0);
        end
        for (int k = 0; k < 128; k++) begin
            send(k == 0, pat(3000 + k), 4'd7, 1'b0);
            exp_q.push_back(pat(3000 + k));
            if (k == 0) chk("t5_restart_err", 64'(err_sop), 64'd1);
            if (k == 1) chk("t5_restart_err_end", 64'(err_sop), 64'd0);
        end
        in_valid = 1'b0;
        check_block("t5", 128, 1, 4'd7);

        // Clamp 15 -> 12, then reset at output beat 100
        for (int k = 0; k < 4096; k++) begin
            send(k == 0, pat(k), 4'd15, 1'b0);
            if (k < 100) exp_q.push_back(pat(k));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 500 && got_q.size() < 100; i++) tick();
        chk("t6_beats_before_rst", 64'(got_q.size()), 64'd100);
        for (int j = 0; j < 100 && j < got_q.size(); j++) begin
            chk("t6_data", got_q[j], exp_q[j]);
            chk("t6_flags", 64'(got_fl[j]), 64'({(j == 0), 1'b0, 4'd12}));
        end
        areset = 1'b1;
        #1;
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_out_data", out_data, 64'd0);
        chk("t6_rst_out_flags", 64'({out_sop, out_eop, out_nfft_log2, err_sop}), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        got_q.delete();
        got_fl.delete();
        exp_q.delete();
        tick();
        tick();
        areset = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        chk("t6_no_output_after_rst", 64'(got_q.size()), 64'd0);
        chk("t6_out_valid_after_rst", 64'(out_valid), 64'd0);
        chk("t6_in_ready_after_rst", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
